// File: rtl/l1_wb_cache_pkg.sv
// Shared geometry, state encoding and address helpers
// for the direct-mapped write-back L1 cache.
package cache_types;

  localparam int TAG_W    = 24;
  localparam int IDX_W    = 3;
  localparam int OFF_W    = 5;
  localparam int NUM_SETS = 8;
  localparam int BEATS    = 4;
  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    RESP
  } cache_state_t;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [2:0]        woff_t;
  typedef logic [1:0]        beat_t;
  typedef logic [LINE_W-1:0] line_t;

  function automatic logic [31:0] line_addr(
    input tag_t t,
    input idx_t i
  );
    return {t, i, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/l1_wb_cache_line_array.sv
// Flop storage for per-set valid/dirty/tag/data with a
// combinational read port, a fill beat port and a byte-enabled word port.
module cache_line_array
  import cache_types::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  idx_t              rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output tag_t              rd_tag_o,
  output line_t             rd_data_o,
  input  logic              fill_we_i,
  input  idx_t              fill_idx_i,
  input  beat_t             fill_beat_i,
  input  logic [BEAT_W-1:0] fill_data_i,
  input  logic              fill_done_i,
  input  tag_t              fill_tag_i,
  input  logic              word_we_i,
  input  idx_t              word_idx_i,
  input  woff_t             word_off_i,
  input  logic [3:0]        word_be_i,
  input  logic [31:0]       word_data_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  tag_t                tag_q  [NUM_SETS];
  line_t               data_q [NUM_SETS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_done_i) begin
        valid_q[fill_idx_i] <= 1'b1;
        dirty_q[fill_idx_i] <= 1'b0;
      end
      if (word_we_i) begin
        dirty_q[word_idx_i] <= 1'b1;
      end
    end
  end

  // Tags and data carry no reset; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (fill_done_i) begin
      tag_q[fill_idx_i] <= fill_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      data_q[fill_idx_i][BEAT_W*int'(fill_beat_i) +: BEAT_W]
        <= fill_data_i;
    end
    if (word_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (word_be_i[b]) begin
          data_q[word_idx_i][32*int'(word_off_i) + 8*b +: 8]
            <= word_data_i[8*b +: 8];
        end
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/l1_wb_cache.sv
// Direct-mapped write-back write-allocate L1: single-word core port,
// 64-bit 4-beat burst port toward physical memory.
module l1_wb_cache
  import cache_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  cache_state_t state_q, state_d;
  beat_t        beat_q, beat_d;
  logic [31:0]  rdata_q, rdata_d;

  tag_t  req_tag;
  idx_t  req_idx;
  woff_t req_off;
  logic  unused_addr;

  assign req_tag     = mem_address[31:8];
  assign req_idx     = mem_address[7:5];
  assign req_off     = mem_address[4:2];
  assign unused_addr = ^mem_address[1:0];

  logic  rd_valid;
  logic  rd_dirty;
  tag_t  rd_tag;
  line_t rd_data;
  logic  fill_we;
  logic  fill_done;
  logic  word_we;
  logic  hit;
  logic  req;

  cache_line_array u_lines (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_idx_i    (req_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .fill_we_i   (fill_we),
    .fill_idx_i  (req_idx),
    .fill_beat_i (beat_q),
    .fill_data_i (pmem_rdata),
    .fill_done_i (fill_done),
    .fill_tag_i  (req_tag),
    .word_we_i   (word_we),
    .word_idx_i  (req_idx),
    .word_off_i  (req_off),
    .word_be_i   (mem_byte_enable),
    .word_data_i (mem_wdata)
  );

  assign req = mem_read | mem_write;
  assign hit = rd_valid && (rd_tag == req_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rdata_d   = rdata_q;
    fill_we   = 1'b0;
    fill_done = 1'b0;
    word_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_d = RESP;
            if (mem_read) begin
              rdata_d = rd_data[32*int'(req_off) +: 32];
            end
          end else if (rd_valid && rd_dirty) begin
            state_d = WB;
          end else begin
            state_d = FILL;
          end
        end
      end
      WB: begin
        if (pmem_resp) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (pmem_resp) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      RESP: begin
        // Request is still held here; the merge uses it before it drops.
        word_we = mem_write;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      WB: begin
        pmem_address = line_addr(rd_tag, req_idx);
        pmem_wdata   = rd_data[BEAT_W*int'(beat_q) +: BEAT_W];
      end
      FILL: begin
        pmem_address = line_addr(req_tag, req_idx);
      end
      default: begin
        pmem_address = '0;
      end
    endcase
  end

  assign mem_resp   = (state_q == RESP);
  assign pmem_read  = (state_q == FILL);
  assign pmem_write = (state_q == WB);
  assign mem_rdata  = rdata_q;

endmodule

// File: tb/tb_l1_wb_cache.sv
// Bench for l1_wb_cache: flat golden memory plus tag-level hit/miss
// model, random-latency burst memory, directed and random traffic.
module tb_l1_wb_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;

  l1_wb_cache dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Physical memory by 8-byte beat address; unwritten beats use a pattern.
  logic [63:0] phys [logic [31:0]];
  // Core-visible memory by word address; absent words equal phys.
  logic [31:0] gold [logic [31:0]];

  function automatic logic [63:0] phys_rd(input logic [31:0] a);
    if (phys.exists(a)) return phys[a];
    return {~a, a ^ 32'hA5A5_0000};
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    logic [63:0] b;
    if (gold.exists(a)) return gold[a];
    b = phys_rd({a[31:3], 3'b000});
    return a[2] ? b[63:32] : b[31:0];
  endfunction

  // Tag-level model of what each set holds.
  logic        mv [8];
  logic        md [8];
  logic [23:0] mt [8];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
    end
    gold.delete();
  endtask

  int          wb_beats = 0;
  int          fill_beats = 0;
  int          last_fill_cyc = 0;
  logic [31:0] last_wb_addr = '0;
  logic [31:0] last_fill_addr = '0;
  logic [31:0] exp_wb_addr = '0;
  logic [31:0] exp_fill_addr = '0;

  // Burst memory: random stall per beat, tolerant of aborted bursts.
  int rbeat = 0;
  int rkind = 0;
  always @(negedge clk) begin
    int kind;
    logic [31:0] a;
    pmem_resp = 1'b0;
    if (rst) begin
      rbeat = 0;
      rkind = 0;
    end else begin
      kind = pmem_write ? 1 : (pmem_read ? 2 : 0);
      if (kind != rkind) rbeat = 0;
      rkind = kind;
      if (kind != 0 && rbeat < 4 && $urandom_range(2) != 0) begin
        a = pmem_address + 32'(8 * rbeat);
        if (kind == 1) begin
          chk("wb_addr", 64'(pmem_address), 64'(exp_wb_addr));
          chk("wb_data", pmem_wdata, {gold_rd(a + 32'd4), gold_rd(a)});
          phys[a] = pmem_wdata;
          last_wb_addr = pmem_address;
          wb_beats++;
        end else begin
          chk("fill_addr", 64'(pmem_address), 64'(exp_fill_addr));
          pmem_rdata = phys_rd(a);
          last_fill_addr = pmem_address;
          fill_beats++;
          if (rbeat == 3) last_fill_cyc = cyc;
        end
        pmem_resp = 1'b1;
        rbeat++;
      end
    end
  end

  // Per-cycle protocol checks.
  logic        prev_resp = 1'b0;
  int          prev_kind = 0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    int kind;
    if (!rst) begin
      kind = pmem_write ? 1 : (pmem_read ? 2 : 0);
      chk("rd_wr_excl", 64'(pmem_read && pmem_write), 64'd0);
      chk("resp_pulse", 64'(prev_resp && mem_resp), 64'd0);
      if (kind != 0) begin
        chk("addr_align", 64'(pmem_address[4:0]), 64'd0);
        if (kind == prev_kind)
          chk("addr_const", 64'(pmem_address), 64'(prev_addr));
      end
      prev_resp = mem_resp;
      prev_kind = kind;
      prev_addr = pmem_address;
    end else begin
      prev_resp = 1'b0;
      prev_kind = 0;
    end
  end

  task automatic do_req(input bit rd, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    logic [2:0]  idx;
    logic [23:0] tag;
    logic [31:0] wa;
    logic [31:0] w;
    bit          hit;
    bit          ewb;
    bit          got;
    int          n;
    idx = addr[7:5];
    tag = addr[31:8];
    wa  = {addr[31:2], 2'b00};
    hit = mv[idx] && mt[idx] == tag;
    ewb = !hit && mv[idx] && md[idx];
    exp_wb_addr   = {mt[idx], idx, 5'b0};
    exp_fill_addr = {tag, idx, 5'b0};
    @(negedge clk);
    wb_beats   = 0;
    fill_beats = 0;
    mem_read        = rd;
    mem_write       = !rd;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    n   = 0;
    got = 0;
    while (n < 300 && !got) begin
      @(negedge clk);
      n++;
      if (mem_resp === 1'b1) got = 1;
    end
    chk("resp_seen", 64'(got), 64'd1);
    if (got) begin
      if (rd) chk("rdata", 64'(mem_rdata), 64'(gold_rd(wa)));
      chk("wb_beats", 64'(wb_beats), ewb ? 64'd4 : 64'd0);
      chk("fill_beats", 64'(fill_beats), hit ? 64'd0 : 64'd4);
      if (hit) chk("hit_lat", 64'(n), 64'd1);
      else chk("miss_lat", 64'(cyc - last_fill_cyc), 64'd2);
    end
    if (!rd) begin
      w = gold_rd(wa);
      for (int b = 0; b < 4; b++)
        if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      gold[wa] = w;
    end
    md[idx] = (hit ? md[idx] : 1'b0) | !rd;
    mv[idx] = 1'b1;
    mt[idx] = tag;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_resp", 64'(mem_resp), 64'd0);
    chk("rst_pmem_read", 64'(pmem_read), 64'd0);
    chk("rst_pmem_write", 64'(pmem_write), 64'd0);
    chk("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_pmem_addr", 64'(pmem_address), 64'd0);
    chk("rst_pmem_wdata", pmem_wdata, 64'd0);
    rst = 1'b0;

    phys[32'h100] = 64'h1111_1111_1111_0000;
    phys[32'h108] = 64'h2222_2222_1122_3344;
    phys[32'h110] = 64'h3333_3333_3333_3333;
    phys[32'h118] = 64'h4444_4444_4444_4444;

    do_req(1, 32'h0000_0104, 4'h0, 32'h0);
    chk("cold_rdata", 64'(mem_rdata), 64'h1111_1111);
    chk("cold_fill_addr", 64'(last_fill_addr), 64'h100);
    do_req(1, 32'h0000_0104, 4'h0, 32'h0);
    chk("hit_rdata", 64'(mem_rdata), 64'h1111_1111);
    do_req(0, 32'h0000_0108, 4'b0101, 32'hDEAD_BEEF);
    do_req(1, 32'h0000_0108, 4'h0, 32'h0);
    chk("merge_rdata", 64'(mem_rdata), 64'h11AD_33EF);
    do_req(1, 32'h0000_1108, 4'h0, 32'h0);
    chk("evict_wb_addr", 64'(last_wb_addr), 64'h100);
    chk("evict_wb_beat1", phys[32'h108], 64'h2222_2222_11AD_33EF);
    chk("evict_fill_addr", 64'(last_fill_addr), 64'h1100);

    // Reset in the middle of a fill burst.
    @(negedge clk);
    fill_beats = 0;
    exp_fill_addr = 32'h0000_2040;
    mem_read    = 1'b1;
    mem_address = 32'h0000_2040;
    ok = 0;
    n  = 0;
    while (n < 200 && !ok) begin
      @(negedge clk);
      #1;
      n++;
      if (fill_beats >= 2) ok = 1;
    end
    chk("fill_started", 64'(ok), 64'd1);
    rst      = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_pmem_read", 64'(pmem_read), 64'd0);
    chk("abort_pmem_write", 64'(pmem_write), 64'd0);
    chk("abort_mem_resp", 64'(mem_resp), 64'd0);
    rst = 1'b0;
    model_reset();
    do_req(1, 32'h0000_2040, 4'h0, 32'h0);

    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      a = {22'd0, 2'($urandom_range(3)), 3'($urandom), 5'($urandom)};
      do_req(1'($urandom), a, 4'($urandom), $urandom);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
